// File: rtl/myproject_pkg.sv
// myproject_pkg: shared types and constants for the myproject inference core.
//   DATA_W / FRAC_W / ACC_W : word, fraction and accumulator widths (Q6.10 data)
//   B_H3 / B_OUT           : bias constants 0.25 and 1.0 in LSB units
//   state_t                : control FSM state encoding
//   sext / zext            : widen a DATA_W word to ACC_W
//   relu_clamp             : ReLU followed by clamp to [0, 32767]
package myproject_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam int ACC_W  = 24;

  localparam logic signed [ACC_W-1:0] B_H3  = ACC_W'(256);
  localparam logic signed [ACC_W-1:0] B_OUT = ACC_W'(1024);

  // Largest positive DATA_W value, held in accumulator width.
  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'(32767);
  // Most negative DATA_W value, held in accumulator width.
  localparam logic signed [ACC_W-1:0] NEG_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v[ACC_W-1]) begin
      r = '0;
    end else if (v > POS_MAX) begin
      r = POS_MAX[DATA_W-1:0];
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_dense_relu.sv
// myproject_dense_relu: combinational 3-input, 4-neuron hidden layer with ReLU
// and clamp to [0, 32767]. Weights are fixed shifts/adds, so no multipliers.
//   x      in  3*DATA_W  packed features {x0, x1, x2}, each signed Q6.10
//   h0..h3 out DATA_W    hidden activations, non-negative Q6.10
module myproject_dense_relu
  import myproject_pkg::*;
(
  input  logic [3*DATA_W-1:0] x,
  output logic [DATA_W-1:0]   h0,
  output logic [DATA_W-1:0]   h1,
  output logic [DATA_W-1:0]   h2,
  output logic [DATA_W-1:0]   h3
);

  logic signed [ACC_W-1:0] x0;
  logic signed [ACC_W-1:0] x1;
  logic signed [ACC_W-1:0] x2;

  assign x0 = sext(x[3*DATA_W-1:2*DATA_W]);
  assign x1 = sext(x[2*DATA_W-1:DATA_W]);
  assign x2 = sext(x[DATA_W-1:0]);

  // x2 * 0.5 is an arithmetic shift, i.e. floor toward minus infinity.
  assign h0 = relu_clamp(x0 + x1 + x2);
  assign h1 = relu_clamp(x0 - x1);
  assign h2 = relu_clamp((x2 >>> 1) - x0);
  assign h3 = relu_clamp(x1 + B_H3);

endmodule

// File: rtl/myproject.sv
// myproject: fixed-function 3-4-1 inference core with start/done handshake.
// Sequence: IDLE -> L1 (register hidden layer) -> L2 (register output)
//           -> DONE (one-cycle done) -> IDLE.
// Handshake: an inference is accepted on a rising edge where the core is in
// IDLE, ap_start=1 and fc1_input_ap_vld=1; ap_ready is high combinationally in
// exactly that cycle. ap_done/layer13_out_ap_vld pulse for the single DONE
// cycle; layer13_out holds until the next DONE. Start is not sampled outside
// IDLE.
// Configuration macro OUT_SAT_EN: defined -> output saturates to 16-bit range;
// undefined -> output wraps to its low 16 bits.
// Ports:
//   ap_clk, ap_rst (async, active low)
//   ap_start, ap_done, ap_idle, ap_ready : control handshake
//   fc1_input[47:0], fc1_input_ap_vld    : packed features {x0,x1,x2}
//   layer13_out[15:0], layer13_out_ap_vld: result y, Q6.10
//   dbg_state                            : current FSM state for observation
module myproject
  import myproject_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [3*DATA_W-1:0] fc1_input,
  input  logic                fc1_input_ap_vld,
  output logic [DATA_W-1:0]   layer13_out,
  output logic                layer13_out_ap_vld,
  output state_t              dbg_state
);

  state_t                state_q;
  state_t                state_d;
  logic [3*DATA_W-1:0]   x_q;
  logic [DATA_W-1:0]     h0_q, h1_q, h2_q, h3_q;
  logic [DATA_W-1:0]     h0_c, h1_c, h2_c, h3_c;
  logic [DATA_W-1:0]     y_q;
  logic signed [ACC_W-1:0] y_acc;
  logic [DATA_W-1:0]     y_red;

  myproject_dense_relu u_dense (
    .x  (x_q),
    .h0 (h0_c),
    .h1 (h1_c),
    .h2 (h2_c),
    .h3 (h3_c)
  );

  // Output neuron. Hidden values are non-negative, so zero extension is exact.
  assign y_acc = zext(h0_q) - zext(h1_q) + (zext(h2_q) >>> 1)
               + (zext(h3_q) <<< 1) - B_OUT;

`ifdef OUT_SAT_EN
  always_comb begin
    y_red = y_acc[DATA_W-1:0];
    if (y_acc > POS_MAX) begin
      y_red = POS_MAX[DATA_W-1:0];
    end else if (y_acc < NEG_MIN) begin
      y_red = NEG_MIN[DATA_W-1:0];
    end
  end
`else
  assign y_red = y_acc[DATA_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    ap_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by reset so no accept is advertised while held in reset.
        if (ap_rst && ap_start && fc1_input_ap_vld) begin
          ap_ready = 1'b1;
          state_d  = S_L1;
        end
      end
      S_L1:    state_d = S_L2;
      S_L2:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      if (ap_ready) begin
        x_q <= fc1_input;
      end
      if (state_q == S_L1) begin
        h0_q <= h0_c;
        h1_q <= h1_c;
        h2_q <= h2_c;
        h3_q <= h3_c;
      end
      if (state_q == S_L2) begin
        y_q <= y_red;
      end
    end
  end

  assign ap_done            = (state_q == S_DONE);
  assign ap_idle            = (state_q == S_IDLE);
  assign layer13_out        = y_q;
  assign layer13_out_ap_vld = ap_done;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_myproject.sv
// tb_myproject: directed and randomized bench for myproject.
// Expected results come from an integer reference model of the network.
module tb_myproject;
  import myproject_pkg::*;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [47:0] fc1_input;
  logic        fc1_input_ap_vld;
  logic [15:0] layer13_out;
  logic        layer13_out_ap_vld;
  state_t      dbg_state;

  int vectors;
  int miscompares;
  logic [15:0] exp_q[$];

  myproject dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .ap_start           (ap_start),
    .ap_done            (ap_done),
    .ap_idle            (ap_idle),
    .ap_ready           (ap_ready),
    .fc1_input          (fc1_input),
    .fc1_input_ap_vld   (fc1_input_ap_vld),
    .layer13_out        (layer13_out),
    .layer13_out_ap_vld (layer13_out_ap_vld),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ---------------- reference model ----------------
  function automatic int clamp_h(input int v);
    if (v < 0) return 0;
    if (v > 32767) return 32767;
    return v;
  endfunction

  function automatic int floor_half(input int v);
    if (v >= 0) return v / 2;
    return -((-v + 1) / 2);
  endfunction

  function automatic logic [15:0] model(input logic [47:0] x);
    int x0, x1, x2, h0, h1, h2, h3, y;
    x0 = int'($signed(x[47:32]));
    x1 = int'($signed(x[31:16]));
    x2 = int'($signed(x[15:0]));
    h0 = clamp_h(x0 + x1 + x2);
    h1 = clamp_h(x0 - x1);
    h2 = clamp_h(floor_half(x2) - x0);
    h3 = clamp_h(x1 + 256);
    y  = h0 - h1 + h2 / 2 + 2 * h3 - 1024;
`ifdef OUT_SAT_EN
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
`endif
    return y[15:0];
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch one inference with a one-cycle start and check the whole transaction.
  task automatic run_inf(input logic [47:0] x, input logic [15:0] exp);
    int cyc;
    @(negedge ap_clk);
    fc1_input = x; ap_start = 1'b1; fc1_input_ap_vld = 1'b1;
    #1;
    chk("ready_on_accept", ap_ready, 1);
    chk("idle_before_accept", ap_idle, 1);
    exp_q.push_back(exp);
    @(negedge ap_clk);
    ap_start = 1'b0; fc1_input_ap_vld = 1'b0; fc1_input = '0;
    chk("idle_low_busy", ap_idle, 0);
    cyc = 1;
    while (!ap_done && cyc < 10) begin
      @(negedge ap_clk);
      cyc++;
    end
    chk("done_latency", cyc, 3);
    chk("out_vld_eq_done", layer13_out_ap_vld, ap_done);
    if (exp_q.size() > 0) chk("result", layer13_out, exp_q.pop_front());
    @(negedge ap_clk);
    chk("done_one_cycle", ap_done, 0);
    chk("idle_after", ap_idle, 1);
    chk("out_hold", layer13_out, exp);
  endtask

  initial begin
    logic [47:0] x;
    logic [15:0] e;
    int done_cnt, first_k, second_k;
    vectors = 0; miscompares = 0;
    ap_start = 1'b1; fc1_input_ap_vld = 1'b1; fc1_input = 48'h1234_5678_9abc;
    ap_rst = 1'b0;

    // Reset state, with start+vld held to confirm no accept in reset.
    #12;
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_out", layer13_out, 0);
    chk("rst_out_vld", layer13_out_ap_vld, 0);
    ap_start = 1'b0; fc1_input_ap_vld = 1'b0; fc1_input = '0;
    @(negedge ap_clk);
    ap_rst = 1'b1;

    // Directed vectors with hand-computed results.
    run_inf(48'h0001_0002_0003, 16'hFE0A);
    run_inf(48'h0000_0000_0000, 16'hFE00);
    run_inf(48'h0400_FC00_0000, 16'hF400);
`ifdef OUT_SAT_EN
    run_inf(48'h7FFF_7FFF_7FFF, 16'h7FFF);
`else
    run_inf(48'h7FFF_7FFF_7FFF, 16'h7BFD);
`endif
    chk("model_basic", model(48'h0001_0002_0003), 16'hFE0A);

    // Start without vld is ignored.
    @(negedge ap_clk);
    ap_start = 1'b1; fc1_input_ap_vld = 1'b0; fc1_input = 48'h0100_0100_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("novld_ready", ap_ready, 0);
      chk("novld_idle", ap_idle, 1);
      @(negedge ap_clk);
    end
    ap_start = 1'b0;

    // Start during L1 is ignored; the result is from the first vector.
    @(negedge ap_clk);
    ap_start = 1'b1; fc1_input_ap_vld = 1'b1; fc1_input = 48'h0001_0002_0003;
    @(negedge ap_clk);
    fc1_input = 48'h0400_FC00_0000;
    #1;
    chk("l1_start_ready", ap_ready, 0);
    @(negedge ap_clk);
    ap_start = 1'b0; fc1_input_ap_vld = 1'b0;
    @(negedge ap_clk);
    chk("l1_start_done", ap_done, 1);
    chk("l1_start_result", layer13_out, 16'hFE0A);
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk("l1_start_no_second", ap_done, 0);
    end

    // Held start relaunches: results four cycles apart.
    ap_start = 1'b1; fc1_input_ap_vld = 1'b1; fc1_input = 48'h0000_0000_0000;
    done_cnt = 0; first_k = -1; second_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        done_cnt++;
        if (first_k < 0) first_k = k; else second_k = k;
        chk("held_result", layer13_out, 16'hFE00);
      end
    end
    ap_start = 1'b0; fc1_input_ap_vld = 1'b0;
    chk("held_done_count", done_cnt, 2);
    chk("held_first", first_k, 3);
    chk("held_interval", second_k - first_k, 4);
    repeat (4) @(negedge ap_clk);

    // Reset asserted during L2 aborts the inference.
    ap_start = 1'b1; fc1_input_ap_vld = 1'b1; fc1_input = 48'h0400_FC00_0000;
    @(negedge ap_clk);
    ap_start = 1'b0; fc1_input_ap_vld = 1'b0;
    @(negedge ap_clk);
    chk("pre_rst_out_nonzero", (layer13_out != 16'h0), 1);
    ap_rst = 1'b0;
    #1;
    chk("midrst_idle", ap_idle, 1);
    chk("midrst_done", ap_done, 0);
    chk("midrst_out", layer13_out, 0);
    chk("midrst_vld", layer13_out_ap_vld, 0);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk("midrst_no_done", ap_done, 0);
    end
    run_inf(48'h0001_0002_0003, 16'hFE0A);

    // Randomized vectors against the reference model.
    for (int n = 0; n < 40; n++) begin
      for (int f = 0; f < 3; f++) begin
        logic [15:0] v;
        if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(0, 4096)) - 16'd2048;
        else v = 16'($urandom);
        x = {x[31:0], v};
      end
      e = model(x);
      run_inf(x, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
